router_reg: RTL

//  Datapath register stage directly downstream of router_fsm in the 1x3 router.
//  - Latches the header byte and re-inserts it ahead of the payload.
//  - Buffers one byte while the destination FIFO is full.
//  - Accumulates running XOR parity and compares it to the trailing parity byte.
//  - Returns parity_done / low_pkt_valid to router_fsm and drives dout to the FIFOs.

---
 rtl/router_pkg.sv | 19 +
 rtl/router_parity_acc.sv | 27 ++
 rtl/router_reg.sv | 108 ++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared constants and address decode helpers for the 1x3 router datapath.
package router_pkg;

   localparam int unsigned DATA_WIDTH = 8;
   localparam int unsigned ADDR_LSB   = 0;
   localparam int unsigned ADDR_MSB   = 1;

   typedef enum logic [1:0] {
      ADDR_FIFO0   = 2'b00,
      ADDR_FIFO1   = 2'b01,
      ADDR_FIFO2   = 2'b10,
      INVALID_ADDR = 2'b11
   } addr_e;

   function automatic logic addr_is_valid(input logic [1:0] addr);
      return addr != INVALID_ADDR;
   endfunction

endpackage

// File: rtl/router_parity_acc.sv
// Running XOR parity over header and payload bytes; cleared at the start of each packet.
module router_parity_acc #(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  clear,
   input  logic                  lfd_state,
   input  logic                  acc_en,
   input  logic [DATA_WIDTH-1:0] header,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] parity
);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         parity <= '0;
      end else if (clear) begin
         parity <= '0;
      end else if (lfd_state) begin
         parity <= parity ^ header;
      end else if (acc_en) begin
         parity <= parity ^ data_in;
      end
   end

endmodule

// File: rtl/router_reg.sv
// Router datapath register stage: header re-insertion, full-FIFO byte buffer, parity check.
// Parity checking is present only when ROUTER_PARITY_CHECK_EN is defined; otherwise err is 0.
module router_reg
   import router_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = router_pkg::DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  pkt_valid,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  fifo_full,
   input  logic                  detect_add,
   input  logic                  lfd_state,
   input  logic                  ld_state,
   input  logic                  laf_state,
   input  logic                  full_state,
   input  logic                  rst_int_reg,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  parity_done,
   output logic                  low_pkt_valid,
   output logic                  err
);

   logic [DATA_WIDTH-1:0] header_reg;
   logic [DATA_WIDTH-1:0] full_byte;
   logic                  header_load;

   assign header_load = detect_add & pkt_valid & addr_is_valid(data_in[ADDR_MSB:ADDR_LSB]);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         header_reg <= '0;
         full_byte  <= '0;
         dout       <= '0;
      end else begin
         if (header_load) header_reg <= data_in;
         if (ld_state && fifo_full) full_byte <= data_in;
         if (lfd_state) begin
            dout <= header_reg;
         end else if (ld_state && !fifo_full) begin
            dout <= data_in;
         end else if (laf_state) begin
            dout <= full_byte;
         end
      end
   end

   // The laf term covers a parity byte that arrived while the FIFO was full.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         parity_done   <= 1'b0;
         low_pkt_valid <= 1'b0;
      end else begin
         if (detect_add) begin
            parity_done <= 1'b0;
         end else if ((ld_state && !fifo_full && !pkt_valid) ||
                      (laf_state && low_pkt_valid && !parity_done)) begin
            parity_done <= 1'b1;
         end
         if (rst_int_reg) begin
            low_pkt_valid <= 1'b0;
         end else if (ld_state && !pkt_valid) begin
            low_pkt_valid <= 1'b1;
         end
      end
   end

`ifdef ROUTER_PARITY_CHECK_EN
   logic [DATA_WIDTH-1:0] int_parity;
   logic [DATA_WIDTH-1:0] pkt_parity;
   logic                  parity_done_q;

   router_parity_acc #(.DATA_WIDTH(DATA_WIDTH)) u_parity_acc (
      .clk       (clk),
      .rstn      (rstn),
      .clear     (detect_add),
      .lfd_state (lfd_state),
      .acc_en    (ld_state & pkt_valid & ~full_state),
      .header    (header_reg),
      .data_in   (data_in),
      .parity    (int_parity)
   );

   // err is sampled on the cycle after parity_done rises, once pkt_parity is stable.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pkt_parity    <= '0;
         parity_done_q <= 1'b0;
         err           <= 1'b0;
      end else begin
         parity_done_q <= parity_done;
         if (detect_add) begin
            pkt_parity <= '0;
            err        <= 1'b0;
         end else begin
            if (ld_state && !pkt_valid) pkt_parity <= data_in;
            if (parity_done && !parity_done_q) err <= (int_parity != pkt_parity);
         end
      end
   end
`else
   logic unused_full_state;
   assign unused_full_state = full_state;
   assign err = 1'b0;
`endif

endmodule
